// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared types and constants for the up/down modulo counter.
//   cnt_state_t : RUN/HALT state of the one-shot FSM.
//   CNT_UP/CNT_DN : encodings of the up_dn input.
package counter_pkg;

  typedef enum logic {
    CNT_RUN  = 1'b0,
    CNT_HALT = 1'b1
  } cnt_state_t;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

endpackage : counter_pkg

// File: rtl/tick_prescaler.sv
// tick_prescaler
//   Clock-enable divider. While en is high the internal count psc advances
//   once per cycle; tick is asserted (combinationally) on the enabled cycle
//   where psc equals div, and psc returns to 0 on that edge.
// Ports
//   clk  in  1           clock
//   rstn in  1           synchronous active-low reset (psc -> 0)
//   en   in  1           enable; en=0 freezes psc and suppresses tick
//   clr  in  1           synchronous clear of psc
//   div  in  PRESCALE_W  divide value; one tick every div+1 enabled cycles
//   tick out 1           qualified count strobe for the current cycle
module tick_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] psc_reg;
  logic [PRESCALE_W-1:0] psc_next;

  assign tick = en && (psc_reg == div);

  always_comb begin
    psc_next = psc_reg;
    if (clr) begin
      psc_next = '0;
    end else if (en) begin
      // ">=" also covers div having been lowered below the current count:
      // psc then restarts from 0 on the next enabled cycle without a tick.
      if (psc_reg >= div) begin
        psc_next = '0;
      end else begin
        psc_next = psc_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      psc_reg <= '0;
    end else begin
      psc_reg <= psc_next;
    end
  end

endmodule : tick_prescaler

// File: rtl/updown_mod_counter.sv
// updown_mod_counter
//   Parametrised up/down modulo counter (range 0..MOD-1) with prescaled
//   clock enable, parallel load (clamped to MOD-1), synchronous clear,
//   wrap or one-shot mode, a registered terminal-count pulse and optional
//   value capture.
//   Optional feature macro: COUNTER_CAPTURE_EN (adds the cap_val register;
//   without it cap is ignored and cap_val is tied to 0).
// Parameters: WIDTH sets the counter width (1..32), the modulus parameter
//   selects the count range (2 up to 2**WIDTH), PRESCALE_W sizes presc_div.
// Ports
//   clk       in  1           clock
//   rstn      in  1           synchronous active-low reset
//   en        in  1           count enable (gates prescaler and counter)
//   up_dn     in  1           1 = up, 0 = down
//   oneshot   in  1           1 = halt at terminal value, 0 = wrap
//   clr       in  1           synchronous clear to 0
//   load      in  1           synchronous parallel load
//   load_val  in  WIDTH       load value (clamped to MOD-1)
//   presc_div in  PRESCALE_W  count once every presc_div+1 enabled cycles
//   cap       in  1           capture strobe
//   out       out WIDTH       current count
//   tc        out 1           one-cycle terminal-count pulse
//   done      out 1           high while halted in one-shot mode
//   cap_val   out WIDTH       captured count
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH      = 8,
  parameter longint unsigned MOD        = 256,
  parameter int              PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  oneshot,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] presc_div,
  input  logic                  cap,
  output logic [WIDTH-1:0]      out,
  output logic                  tc,
  output logic                  done,
  output logic [WIDTH-1:0]      cap_val
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);

  logic             tick;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             tc_reg, tc_next;
  logic             done_reg, done_next;
  cnt_state_t       state_reg, state_next;

  // load and clr both restart the prescaler phase.
  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_presc (
    .clk (clk),
    .rstn(rstn),
    .en  (en),
    .clr (clr | load),
    .div (presc_div),
    .tick(tick)
  );

  always_comb begin
    out_next   = out_reg;
    tc_next    = 1'b0;
    state_next = state_reg;
    if (clr) begin
      out_next   = '0;
      state_next = CNT_RUN;
    end else if (load) begin
      out_next   = (load_val > MAXV) ? MAXV : load_val;
      state_next = CNT_RUN;
    end else if (tick && (state_reg == CNT_RUN)) begin
      if (up_dn == CNT_UP) begin
        if (out_reg == MAXV) begin
          tc_next = 1'b1;
          // One-shot holds at the terminal value instead of wrapping.
          if (oneshot) state_next = CNT_HALT;
          else         out_next   = '0;
        end else begin
          out_next = out_reg + 1'b1;
        end
      end else begin
        if (out_reg == '0) begin
          tc_next = 1'b1;
          if (oneshot) state_next = CNT_HALT;
          else         out_next   = MAXV;
        end else begin
          out_next = out_reg - 1'b1;
        end
      end
    end
    done_next = (state_next == CNT_HALT);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_reg   <= '0;
      tc_reg    <= 1'b0;
      done_reg  <= 1'b0;
      state_reg <= CNT_RUN;
    end else begin
      out_reg   <= out_next;
      tc_reg    <= tc_next;
      done_reg  <= done_next;
      state_reg <= state_next;
    end
  end

  assign out  = out_reg;
  assign tc   = tc_reg;
  assign done = done_reg;

`ifdef COUNTER_CAPTURE_EN
  // Captures the pre-update count; only reset clears it (clr/load do not).
  logic [WIDTH-1:0] cap_val_reg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cap_val_reg <= '0;
    end else if (cap) begin
      cap_val_reg <= out_reg;
    end
  end

  assign cap_val = cap_val_reg;
`else
  logic unused_cap;
  assign unused_cap = cap;
  assign cap_val    = '0;
`endif

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter
//   Directed bench for updown_mod_counter (WIDTH=8, MOD=10, PRESCALE_W=4).
//   Each step drives inputs on the falling edge, pushes the expected
//   post-edge outputs to a scoreboard queue, and pops/compares them on the
//   next falling edge. One line is printed per transaction.
module tb_updown_mod_counter;

  localparam int WIDTH = 8;
  localparam int PW    = 4;

  logic             clk = 1'b0;
  logic             rstn, en, up_dn, oneshot, clr, load, cap;
  logic [WIDTH-1:0] load_val;
  logic [PW-1:0]    presc_div;
  logic [WIDTH-1:0] out, cap_val;
  logic             tc, done;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             done;
    logic [WIDTH-1:0] cap;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic [WIDTH-1:0] exp_cap = '0;

  updown_mod_counter #(
    .WIDTH(WIDTH), .MOD(10), .PRESCALE_W(PW)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .oneshot(oneshot),
    .clr(clr), .load(load), .load_val(load_val), .presc_div(presc_div),
    .cap(cap), .out(out), .tc(tc), .done(done), .cap_val(cap_val)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One transaction: expectation in, one clock edge, expectation out.
  task automatic step(input string tag, input logic [WIDTH-1:0] e_out,
                      input logic e_tc, input logic e_done);
    exp_t e;
    exp_q.push_back('{tag, e_out, e_tc, e_done, exp_cap});
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    $display("%-10s out=%0d tc=%0b done=%0b cap_val=%0d (exp %0d/%0b/%0b/%0d)",
             e.tag, out, tc, done, cap_val, e.out, e.tc, e.done, e.cap);
    checks++;
    assert (out === e.out) else begin
      failures++; $error("FAIL %s out: got %0d expected %0d", e.tag, out, e.out);
    end
    checks++;
    assert (tc === e.tc) else begin
      failures++; $error("FAIL %s tc: got %0b expected %0b", e.tag, tc, e.tc);
    end
    checks++;
    assert (done === e.done) else begin
      failures++; $error("FAIL %s done: got %0b expected %0b", e.tag, done, e.done);
    end
    checks++;
    assert (cap_val === e.cap) else begin
      failures++; $error("FAIL %s cap_val: got %0d expected %0d", e.tag, cap_val, e.cap);
    end
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; up_dn = 1'b1; oneshot = 1'b0; clr = 1'b0;
    load = 1'b0; cap = 1'b0; load_val = '0; presc_div = '0;

    // Reset
    step("reset", 0, 0, 0);
    step("reset", 0, 0, 0);

    // 1. Up count, wrap 9->0 with tc
    rstn = 1'b1; en = 1'b1;
    for (int k = 1; k <= 9; k++) step("up", WIDTH'(k), 0, 0);
    step("up_wrap", 0, 1, 0);
    step("up", 1, 0, 0);

    // 2. Down from 2, wrap 0->9, clamp on load
    up_dn = 1'b0; load = 1'b1; load_val = 8'd2;
    step("ld2", 2, 0, 0);
    load = 1'b0;
    step("dn", 1, 0, 0);
    step("dn", 0, 0, 0);
    step("dn_wrap", 9, 1, 0);
    step("dn", 8, 0, 0);
    load = 1'b1; load_val = 8'd200;
    step("ld_clamp", 9, 0, 0);

    // 3. Prescaler divide by 4, freeze with en=0
    up_dn = 1'b1; load_val = 8'd0; presc_div = 4'd3;
    step("ld0", 0, 0, 0);
    load = 1'b0;
    for (int k = 1; k <= 10; k++) step("presc", WIDTH'(k / 4), 0, 0);
    en = 1'b0;
    for (int k = 0; k < 5; k++) step("frozen", 2, 0, 0);
    en = 1'b1;
    step("resume", 2, 0, 0);
    step("resume", 3, 0, 0);
    step("resume", 3, 0, 0);

    // 4. One-shot up: 7,8,9 then hold with single tc
    presc_div = 4'd0; oneshot = 1'b1; load = 1'b1; load_val = 8'd7;
    step("os_ld7", 7, 0, 0);
    load = 1'b0;
    step("os", 8, 0, 0);
    step("os", 9, 0, 0);
    step("os_term", 9, 1, 1);
    step("os_hold", 9, 0, 1);
    step("os_hold", 9, 0, 1);
    load = 1'b1; load_val = 8'd0;
    step("os_ld0", 0, 0, 0);
    load = 1'b0;
    step("os_run", 1, 0, 0);

    // One-shot down terminal, then leave HALT via clr
    up_dn = 1'b0; load = 1'b1; load_val = 8'd1;
    step("osd_ld1", 1, 0, 0);
    load = 1'b0;
    step("osd", 0, 0, 0);
    step("osd_term", 0, 1, 1);
    step("osd_hold", 0, 0, 1);
    clr = 1'b1;
    step("osd_clr", 0, 0, 0);
    clr = 1'b0; oneshot = 1'b0; up_dn = 1'b1;
    step("run", 1, 0, 0);

    // 6. Capture of the pre-update value (counter keeps counting)
    load = 1'b1; load_val = 8'd6;
    step("ld6", 6, 0, 0);
    load = 1'b0; cap = 1'b1;
`ifdef COUNTER_CAPTURE_EN
    exp_cap = 8'd6;
`endif
    step("cap", 7, 0, 0);
    cap = 1'b0;
    step("cap_hold", 8, 0, 0);

    // 5. clr beats load; reset mid-count
    clr = 1'b1; load = 1'b1; load_val = 8'd5;
    step("clr_ld", 0, 0, 0);
    clr = 1'b0;
    step("ld5", 5, 0, 0);
    load = 1'b0; rstn = 1'b0; exp_cap = '0;
    step("rst_mid", 0, 0, 0);
    rstn = 1'b1;
    step("post_rst", 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_updown_mod_counter
